udma_stream_src: RTL and testbench
==================================

Name: udma_stream_src

Overview:
- Stream transmitter for the uDMA streaming fabric. It is the producer side of the stream port that the filter consumes (stream_id/data/datasize/valid/sot/eot/ready).
- It reads a buffer from L2 through one uDMA TX channel and emits it as one framed stream.
- sot marks the first beat, eot marks the last beat, and the stream is tagged with a programmable stream ID.
- It sits beside the filter in the peripheral subsystem and is configured through the standard uDMA cfg bus.

Parameters:
- DATA_WIDTH, 32: data width of the TX channel and of the stream.
- FILTID_WIDTH, 2: width of the stream ID (tied to udma_pkg::STREAM_ID_WIDTH at instantiation).
- L2_AWIDTH_NOAL, 19: width of the L2 byte address.
- TRANS_SIZE, 20: width of the beat-length counter.
- FIFO_DEPTH, 4: number of response buffer entries; must be a power of two and at least 2.

Ports:
- sys_clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- cfg_data_i  in  32  cfg write data
- cfg_addr_i  in  5  cfg word address
- cfg_valid_i  in  1  cfg access strobe
- cfg_rwn_i  in  1  1 = read, 0 = write
- cfg_ready_o  out  1  cfg ready
- cfg_data_o  out  32  cfg read data
- eot_event_o  out  1  one-cycle pulse at end of transfer
- tx_req_o  out  1  TX channel read request
- tx_addr_o  out  L2_AWIDTH_NOAL  request address
- tx_datasize_o  out  2  request size (0 = byte, 1 = half, 2 = word)
- tx_gnt_i  in  1  request granted
- tx_valid_i  in  1  response data valid
- tx_data_i  in  DATA_WIDTH  response data
- tx_ready_o  out  1  response accept
- str_id_o  out  FILTID_WIDTH  stream ID
- str_data_o  out  DATA_WIDTH  stream data
- str_datasize_o  out  2  stream beat size
- str_valid_o  out  1  stream beat valid
- str_sot_o  out  1  first beat of frame
- str_eot_o  out  1  last beat of frame
- str_ready_i  in  1  consumer accept

Behaviour:
- Reset:
  - All registers, counters and FIFO pointers are 0.
  - FSM is in IDLE.
  - All outputs are 0, except cfg_ready_o = 1.
- Cfg registers (word address):
  - 0 ADDR [L2_AWIDTH_NOAL-1:0]
  - 1 LEN [TRANS_SIZE-1:0], in beats
  - 2 DSIZE [1:0]
  - 3 SID [FILTID_WIDTH-1:0]
  - 4 CTRL: write bit0 = start; read bit0 = busy
  - Unmapped addresses read 0; writes to them are ignored.
- Cfg bus timing:
  - cfg_ready_o is constant 1.
  - cfg_data_o is combinational from cfg_addr_i.
  - Writes to registers 0-3 take effect at the clock edge and are ignored while busy.
- Start:
  - A start write in IDLE with LEN != 0 latches ADDR, LEN, DSIZE and SID into working copies and enters RUN on the next cycle.
  - Start with LEN = 0, or start while busy, is ignored.
- FSM:
  - IDLE -> RUN on a valid start.
  - RUN -> IDLE in the cycle after the eot beat handshake (str_valid_o & str_ready_i & str_eot_o).
  - busy = (state == RUN).
- Request side:
  - tx_req_o = RUN & (req_left != 0) & (outstanding + fifo_count < FIFO_DEPTH).
  - tx_addr_o is the current address; tx_datasize_o is the latched DSIZE.
  - On tx_req_o & tx_gnt_i: address advances by (1 << DSIZE), req_left decrements, outstanding increments.
  - tx_req_o and tx_addr_o stay stable until granted.
- Response side:
  - tx_ready_o = 1 in RUN. The credit rule above guarantees FIFO space.
  - On tx_valid_i: push tx_data_i into the FIFO and decrement outstanding.
  - A grant and a response in the same cycle leave outstanding unchanged.
- Stream side:
  - str_valid_o = FIFO non-empty; str_data_o = FIFO head.
  - str_id_o and str_datasize_o are the latched values during RUN and 0 in IDLE.
  - str_sot_o = str_valid_o & (beats_sent == 0).
  - str_eot_o = str_valid_o & (beats_sent == LEN-1); LEN = 1 asserts sot and eot on the same beat.
  - Once str_valid_o is asserted, data, sot and eot are held until str_ready_i.
  - Pop and beats_sent++ happen on str_valid_o & str_ready_i.
  - Zero-latency FIFO bypass is not required. Minimum latency is one cycle from tx_valid_i to str_valid_o.
  - Push and pop in the same cycle are both allowed at full and at empty.
- eot_event_o pulses for exactly one cycle, in the cycle after the eot handshake, coincident with the return to IDLE.
- Address arithmetic wraps modulo 2^L2_AWIDTH_NOAL. Beat counters are TRANS_SIZE wide.
- Reset asserted mid-transfer:
  - Reset asynchronously aborts the transfer and clears all state.
  - Any responses still in flight after reset are ignored, because tx_ready_o = 0 in IDLE.
  - No eot_event_o is generated for an aborted transfer.

Test Plan:
- ADDR=0x100, LEN=4, DSIZE=2, SID=1, start, str_ready_i=1, 1-cycle grant and response:
  - Requests go to addresses 0x100, 0x104, 0x108, 0x10C.
  - The stream carries 4 beats, sot on beat 0, eot on beat 3, str_id_o=1.
  - eot_event_o is a single pulse; CTRL busy reads 0 afterwards.
- LEN=1, DSIZE=0, ADDR=0x7FFFF:
  - One request is issued at 0x7FFFF.
  - The single beat has sot=eot=1.
  - The working address wraps to 0x00000.
- LEN=16, str_ready_i=0 held for 50 cycles:
  - No more than FIFO_DEPTH=4 grants are issued.
  - str_valid_o, data and sot stay stable.
  - After ready is released, all 16 beats arrive in order with no loss or duplication.
- LEN=8, random tx_gnt_i/tx_valid_i/str_ready_i with 30% stalls:
  - The stream sequence exactly matches the L2 model.
  - Exactly one sot and one eot per frame; outstanding never exceeds 4.
- Start writes that must be ignored:
  - Start with LEN=0: busy stays 0, no tx_req_o.
  - Second start and an ADDR write during RUN: the running transfer is unaffected, and ADDR readback keeps its old value.
- Reset mid-transfer (rst_i pulsed after 3 beats of LEN=8):
  - All outputs go to 0 immediately.
  - No eot_event_o is generated.
  - A following start with LEN=2 completes normally.

Source files
------------

// File: rtl/udma_stream_src_if.sv
// Port bundle for udma_stream_src: cfg bus, uDMA TX channel and the outgoing stream.
// The master modport is the source itself; slave is the surrounding subsystem.
interface udma_stream_src_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int FILTID_WIDTH   = 2,
    parameter int L2_AWIDTH_NOAL = 19
);
    logic [31:0]               cfg_data_i;
    logic [4:0]                cfg_addr_i;
    logic                      cfg_valid_i;
    logic                      cfg_rwn_i;
    logic                      cfg_ready_o;
    logic [31:0]               cfg_data_o;
    logic                      eot_event_o;

    logic                      tx_req_o;
    logic [L2_AWIDTH_NOAL-1:0] tx_addr_o;
    logic [1:0]                tx_datasize_o;
    logic                      tx_gnt_i;
    logic                      tx_valid_i;
    logic [DATA_WIDTH-1:0]     tx_data_i;
    logic                      tx_ready_o;

    logic [FILTID_WIDTH-1:0]   str_id_o;
    logic [DATA_WIDTH-1:0]     str_data_o;
    logic [1:0]                str_datasize_o;
    logic                      str_valid_o;
    logic                      str_sot_o;
    logic                      str_eot_o;
    logic                      str_ready_i;

    modport master (
        input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        input  tx_gnt_i, tx_valid_i, tx_data_i, str_ready_i,
        output cfg_ready_o, cfg_data_o, eot_event_o,
        output tx_req_o, tx_addr_o, tx_datasize_o, tx_ready_o,
        output str_id_o, str_data_o, str_datasize_o, str_valid_o, str_sot_o, str_eot_o
    );

    modport slave (
        output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        output tx_gnt_i, tx_valid_i, tx_data_i, str_ready_i,
        input  cfg_ready_o, cfg_data_o, eot_event_o,
        input  tx_req_o, tx_addr_o, tx_datasize_o, tx_ready_o,
        input  str_id_o, str_data_o, str_datasize_o, str_valid_o, str_sot_o, str_eot_o
    );
endinterface

// File: rtl/udma_stream_src.sv
// uDMA stream source: fetches LEN beats from L2 over a TX channel and emits them as
// one sot/eot framed stream tagged with a stream ID.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for a start write with LEN != 0; cfg regs writable
//   ST_RUN  | issuing requests, buffering responses, streaming beats
module udma_stream_src #(
    parameter int DATA_WIDTH     = 32,
    parameter int FILTID_WIDTH   = 2,
    parameter int L2_AWIDTH_NOAL = 19,
    parameter int TRANS_SIZE     = 20,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    udma_stream_src_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [4:0] REG_ADDR  = 5'd0;
    localparam logic [4:0] REG_LEN   = 5'd1;
    localparam logic [4:0] REG_DSIZE = 5'd2;
    localparam logic [4:0] REG_SID   = 5'd3;
    localparam logic [4:0] REG_CTRL  = 5'd4;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e                    state_q;

    logic [L2_AWIDTH_NOAL-1:0] reg_addr_q;
    logic [TRANS_SIZE-1:0]     reg_len_q;
    logic [1:0]                reg_dsize_q;
    logic [FILTID_WIDTH-1:0]   reg_sid_q;

    logic [L2_AWIDTH_NOAL-1:0] addr_q;
    logic [TRANS_SIZE-1:0]     len_q;
    logic [1:0]                dsize_q;
    logic [FILTID_WIDTH-1:0]   sid_q;
    logic [TRANS_SIZE-1:0]     req_left_q;
    logic [TRANS_SIZE-1:0]     beats_sent_q;
    logic [CNT_W-1:0]          outst_q;
    logic [CNT_W-1:0]          fifo_cnt_q;
    logic [PTR_W-1:0]          wptr_q;
    logic [PTR_W-1:0]          rptr_q;
    logic [DATA_WIDTH-1:0]     fifo_q [FIFO_DEPTH];
    logic                      eot_event_q;

    logic                      busy;
    logic                      cfg_wr;
    logic                      start;
    logic [CNT_W:0]            credit_used;
    logic                      tx_req;
    logic                      grant;
    logic                      push;
    logic                      str_valid;
    logic                      pop;
    logic                      eot_beat;
    logic                      last_pop;
    logic [CNT_W-1:0]          outst_d;
    logic [CNT_W-1:0]          fifo_cnt_d;
    logic [L2_AWIDTH_NOAL-1:0] addr_d;
    logic [31:0]               cfg_rdata;
    logic                      unused_cfg_bits;

    assign busy   = (state_q == ST_RUN);
    assign cfg_wr = bus.cfg_valid_i & ~bus.cfg_rwn_i;
    assign start  = cfg_wr & (bus.cfg_addr_i == REG_CTRL) & bus.cfg_data_i[0]
                  & ~busy & (reg_len_q != '0);

    // Requests only go out while every granted beat is guaranteed a FIFO slot.
    assign credit_used = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign tx_req      = busy & (req_left_q != '0) & (credit_used < DEPTH_C);
    assign grant       = tx_req & bus.tx_gnt_i;
    assign push        = busy & bus.tx_valid_i;
    assign str_valid   = (fifo_cnt_q != '0);
    assign pop         = str_valid & bus.str_ready_i;
    assign eot_beat    = (beats_sent_q == (len_q - TRANS_SIZE'(1)));
    assign last_pop    = pop & eot_beat;

    assign outst_d    = outst_q + CNT_W'(grant) - CNT_W'(push);
    assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    assign addr_d     = addr_q + (L2_AWIDTH_NOAL'(1) << dsize_q);

    always_comb begin
        cfg_rdata = '0;
        case (bus.cfg_addr_i)
            REG_ADDR:  cfg_rdata = 32'(reg_addr_q);
            REG_LEN:   cfg_rdata = 32'(reg_len_q);
            REG_DSIZE: cfg_rdata = 32'(reg_dsize_q);
            REG_SID:   cfg_rdata = 32'(reg_sid_q);
            REG_CTRL:  cfg_rdata = 32'(busy);
            default:   cfg_rdata = '0;
        endcase
    end

    // Upper write-data bits have no register behind them.
    assign unused_cfg_bits = ^bus.cfg_data_i;

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            reg_addr_q   <= '0;
            reg_len_q    <= '0;
            reg_dsize_q  <= '0;
            reg_sid_q    <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            dsize_q      <= '0;
            sid_q        <= '0;
            req_left_q   <= '0;
            beats_sent_q <= '0;
            outst_q      <= '0;
            fifo_cnt_q   <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            eot_event_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            eot_event_q <= 1'b0;

            if (cfg_wr && !busy) begin
                case (bus.cfg_addr_i)
                    REG_ADDR:  reg_addr_q  <= bus.cfg_data_i[L2_AWIDTH_NOAL-1:0];
                    REG_LEN:   reg_len_q   <= bus.cfg_data_i[TRANS_SIZE-1:0];
                    REG_DSIZE: reg_dsize_q <= bus.cfg_data_i[1:0];
                    REG_SID:   reg_sid_q   <= bus.cfg_data_i[FILTID_WIDTH-1:0];
                    default:   ;
                endcase
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_RUN;
                        addr_q       <= reg_addr_q;
                        len_q        <= reg_len_q;
                        dsize_q      <= reg_dsize_q;
                        sid_q        <= reg_sid_q;
                        req_left_q   <= reg_len_q;
                        beats_sent_q <= '0;
                    end
                end
                ST_RUN: begin
                    outst_q    <= outst_d;
                    fifo_cnt_q <= fifo_cnt_d;
                    if (grant) begin
                        addr_q     <= addr_d;
                        req_left_q <= req_left_q - TRANS_SIZE'(1);
                    end
                    if (push) begin
                        fifo_q[wptr_q] <= bus.tx_data_i;
                        wptr_q         <= wptr_q + PTR_W'(1);
                    end
                    if (pop) begin
                        rptr_q       <= rptr_q + PTR_W'(1);
                        beats_sent_q <= beats_sent_q + TRANS_SIZE'(1);
                    end
                    // Working address is kept so the post-frame wrap stays visible.
                    if (last_pop) begin
                        state_q      <= ST_IDLE;
                        eot_event_q  <= 1'b1;
                        len_q        <= '0;
                        dsize_q      <= '0;
                        sid_q        <= '0;
                        beats_sent_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_ready_o    = 1'b1;
    assign bus.cfg_data_o     = cfg_rdata;
    assign bus.eot_event_o    = eot_event_q;

    assign bus.tx_req_o       = tx_req;
    assign bus.tx_addr_o      = addr_q;
    assign bus.tx_datasize_o  = dsize_q;
    assign bus.tx_ready_o     = busy;

    assign bus.str_id_o       = sid_q;
    assign bus.str_data_o     = fifo_q[rptr_q];
    assign bus.str_datasize_o = dsize_q;
    assign bus.str_valid_o    = str_valid;
    assign bus.str_sot_o      = str_valid & (beats_sent_q == '0);
    assign bus.str_eot_o      = str_valid & eot_beat;
endmodule

// File: tb/tb_udma_stream_src.sv
// Scoreboard bench for udma_stream_src: an L2 slave answers grants from an address-indexed
// data model, and the stream monitor pops expected beats built from the frame rules.
module tb_udma_stream_src;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int AW = 19;
    localparam int TS = 20;
    localparam int FD = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sot;
        logic          eot;
        logic [SW-1:0] sid;
        logic [1:0]    dsize;
    } beat_t;

    logic sys_clk_i = 1'b0;
    logic rst_i     = 1'b1;
    always #5 sys_clk_i = ~sys_clk_i;

    udma_stream_src_if #(.DATA_WIDTH(DW), .FILTID_WIDTH(SW), .L2_AWIDTH_NOAL(AW)) bus ();

    udma_stream_src #(
        .DATA_WIDTH(DW), .FILTID_WIDTH(SW), .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .FIFO_DEPTH(FD)
    ) dut (
        .sys_clk_i(sys_clk_i),
        .rst_i    (rst_i),
        .bus      (bus)
    );

    beat_t         exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] rsp_q[$];

    int checks = 0, failures = 0;
    int gnt_stall = 0, vld_stall = 0, rdy_stall = 0;
    bit rdy_hold_low = 0;
    int grants_cnt = 0, pops_cnt = 0, eot_pulses = 0, req_cycles = 0;
    int grant_base = 0, pop_base = 0;

    function automatic logic [DW-1:0] l2(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // L2 slave: random grants, in-order responses with random valid stalls.
    initial begin : l2_slave
        logic g, acc, pr_hold;
        logic [AW-1:0] a, hold_a;
        g = 0; acc = 0; pr_hold = 0; a = '0; hold_a = '0;
        bus.tx_gnt_i = 0; bus.tx_valid_i = 0; bus.tx_data_i = '0;
        forever begin
            @(negedge sys_clk_i);
            if (rst_i) begin
                g = 0; acc = 0; pr_hold = 0;
            end else begin
                if (pr_hold) chk("req_stable", 64'({bus.tx_req_o, bus.tx_addr_o}), 64'({1'b1, hold_a}));
                if (bus.tx_req_o) req_cycles++;
                g       = bus.tx_req_o & bus.tx_gnt_i;
                acc     = bus.tx_valid_i & bus.tx_ready_o;
                a       = bus.tx_addr_o;
                pr_hold = bus.tx_req_o & ~bus.tx_gnt_i;
                hold_a  = bus.tx_addr_o;
            end
            @(posedge sys_clk_i); #1;
            if (acc && rsp_q.size() > 0) void'(rsp_q.pop_front());
            if (g) begin
                grants_cnt++;
                checks++;
                if ((grants_cnt - grant_base) - (pops_cnt - pop_base) > FD) begin
                    failures++;
                    $display("FAIL credit: in_flight=%0d required<=%0d",
                             (grants_cnt - grant_base) - (pops_cnt - pop_base), FD);
                end
                if (exp_addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_req: addr=%0h required=no request", a);
                end else begin
                    chk("req_addr", 64'(a), 64'(exp_addr_q.pop_front()));
                end
                rsp_q.push_back(l2(a));
            end
            bus.tx_gnt_i = ($urandom_range(99) >= gnt_stall);
            if (rsp_q.size() > 0 && $urandom_range(99) >= vld_stall) begin
                bus.tx_valid_i = 1; bus.tx_data_i = rsp_q[0];
            end else begin
                bus.tx_valid_i = 0; bus.tx_data_i = $urandom;
            end
        end
    end

    // Stream monitor and consumer: pops the scoreboard on each accepted beat.
    initial begin : str_mon
        logic hold, prev_eot_hs, hs;
        beat_t b, held, e;
        hold = 0; prev_eot_hs = 0; held = '0;
        bus.str_ready_i = 0;
        forever begin
            @(negedge sys_clk_i);
            if (rst_i) begin
                hold = 0; prev_eot_hs = 0;
            end else begin
                if (prev_eot_hs || bus.eot_event_o)
                    chk("eot_event", 64'(bus.eot_event_o), 64'(prev_eot_hs));
                if (bus.eot_event_o) eot_pulses++;
                b.data = bus.str_data_o; b.sot = bus.str_sot_o; b.eot = bus.str_eot_o;
                b.sid = bus.str_id_o; b.dsize = bus.str_datasize_o;
                if (hold) chk("str_hold", 64'({bus.str_valid_o, b}), 64'({1'b1, held}));
                hs          = bus.str_valid_o & bus.str_ready_i;
                prev_eot_hs = hs & bus.str_eot_o;
                hold        = bus.str_valid_o & ~bus.str_ready_i;
                held        = b;
                if (hs) begin
                    pops_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL extra_beat: data=%0h required=no beat", b.data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 64'(b), 64'(e));
                    end
                end
            end
            @(posedge sys_clk_i); #1;
            bus.str_ready_i = rdy_hold_low ? 1'b0 : ($urandom_range(99) >= rdy_stall);
        end
    end

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge sys_clk_i); #2;
        bus.cfg_valid_i = 1; bus.cfg_rwn_i = 0; bus.cfg_addr_i = a; bus.cfg_data_i = d;
        @(negedge sys_clk_i); #2;
        bus.cfg_valid_i = 0;
    endtask

    task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge sys_clk_i); #2;
        bus.cfg_valid_i = 1; bus.cfg_rwn_i = 1; bus.cfg_addr_i = a;
        #1 d = bus.cfg_data_o;
        bus.cfg_valid_i = 0;
    endtask

    task automatic write_regs(input int addr, input int len, input int dsize, input int sid);
        cfg_write(5'd0, 32'(addr));
        cfg_write(5'd1, 32'(len));
        cfg_write(5'd2, 32'(dsize));
        cfg_write(5'd3, 32'(sid));
    endtask

    task automatic start_frame(input int addr, input int len, input int dsize, input int sid);
        beat_t b;
        logic [AW-1:0] a;
        write_regs(addr, len, dsize, sid);
        for (int i = 0; i < len; i++) begin
            a = AW'(addr + (i << dsize));
            exp_addr_q.push_back(a);
            b.data = l2(a); b.sot = (i == 0); b.eot = (i == len - 1);
            b.sid = SW'(sid); b.dsize = 2'(dsize);
            exp_q.push_back(b);
        end
        cfg_write(5'd4, 32'd1);
    endtask

    task automatic wait_eot(input int target, input int budget, input string name);
        int n;
        logic [31:0] d;
        n = 0;
        while (eot_pulses < target && n < budget) begin
            @(negedge sys_clk_i); #1; n++;
        end
        checks++;
        if (eot_pulses < target) begin
            failures++;
            $display("FAIL %s_timeout: eot_pulses=%0d required=%0d", name, eot_pulses, target);
        end
        cfg_read(5'd4, d);
        chk({name, "_busy_after"}, 64'(d), 64'd0);
        chk({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_reqs_left"}, 64'(exp_addr_q.size()), 64'd0);
    endtask

    task automatic do_reset(input bit check_outputs);
        @(posedge sys_clk_i); #3;
        rst_i = 1;
        #1;
        if (check_outputs) begin
            chk("rst_outputs_zero",
                64'({bus.str_valid_o, bus.str_sot_o, bus.str_eot_o, bus.str_id_o, bus.str_datasize_o,
                     bus.tx_req_o, bus.tx_addr_o, bus.tx_datasize_o, bus.tx_ready_o, bus.eot_event_o}), 64'd0);
            chk("rst_str_data", 64'(bus.str_data_o), 64'd0);
            chk("rst_cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
        end
        exp_q.delete(); exp_addr_q.delete(); rsp_q.delete();
        grant_base = grants_cnt; pop_base = pops_cnt;
        @(posedge sys_clk_i); #3;
        rst_i = 0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d;
        int n0, g0, p0, r0, n;
        bus.cfg_valid_i = 0; bus.cfg_rwn_i = 1; bus.cfg_addr_i = '0; bus.cfg_data_i = '0;
        repeat (2) @(posedge sys_clk_i);
        do_reset(1'b1);
        repeat (2) @(negedge sys_clk_i);

        cfg_read(5'd4, d); chk("rst_busy", 64'(d), 64'd0);
        cfg_read(5'd1, d); chk("rst_len", 64'(d), 64'd0);
        cfg_read(5'd9, d); chk("unmapped_read", 64'(d), 64'd0);

        // Basic 4-word frame at full speed.
        n0 = eot_pulses;
        start_frame(32'h100, 4, 2, 1);
        wait_eot(n0 + 1, 100, "t1");
        repeat (5) @(negedge sys_clk_i);
        #1 chk("t1_single_pulse", 64'(eot_pulses), 64'(n0 + 1));

        // Single byte beat at the top of L2 wraps the working address.
        n0 = eot_pulses;
        start_frame(32'h7FFFF, 1, 0, 2);
        wait_eot(n0 + 1, 100, "t2");
        #1 chk("t2_addr_wrap", 64'(bus.tx_addr_o), 64'd0);
        cfg_read(5'd0, d); chk("t2_addr_readback", 64'(d), 64'h7FFFF);

        // Consumer backpressure: credit limits grants to the FIFO depth.
        n0 = eot_pulses; g0 = grants_cnt;
        rdy_hold_low = 1;
        start_frame(32'h2000, 16, 2, 3);
        repeat (50) @(negedge sys_clk_i);
        #1;
        chk("t3_grants_capped", 64'(grants_cnt - g0), 64'(FD));
        chk("t3_valid_sot", 64'({bus.str_valid_o, bus.str_sot_o}), 64'b11);
        rdy_hold_low = 0;
        wait_eot(n0 + 1, 200, "t3");

        // Random stalls on all three handshakes.
        gnt_stall = 30; vld_stall = 30; rdy_stall = 30;
        for (int f = 0; f < 4; f++) begin
            n0 = eot_pulses;
            start_frame(int'($urandom & 32'h7FFFF), 8, int'($urandom_range(2)), int'($urandom_range(3)));
            wait_eot(n0 + 1, 400, "t4");
        end
        gnt_stall = 0; vld_stall = 0; rdy_stall = 0;

        // Start with LEN = 0 is ignored.
        n0 = eot_pulses; r0 = req_cycles;
        write_regs(32'h40, 0, 2, 1);
        cfg_write(5'd4, 32'd1);
        cfg_read(5'd4, d); chk("t5_busy", 64'(d), 64'd0);
        repeat (10) @(negedge sys_clk_i);
        #1 chk("t5_no_req", 64'(req_cycles - r0), 64'd0);
        chk("t5_no_eot", 64'(eot_pulses), 64'(n0));

        // Cfg writes and a second start during RUN are ignored.
        rdy_stall = 70;
        n0 = eot_pulses;
        start_frame(32'h300, 8, 1, 2);
        cfg_read(5'd4, d); chk("t6_busy", 64'(d), 64'd1);
        cfg_write(5'd0, 32'h555);
        cfg_write(5'd1, 32'd3);
        cfg_write(5'd4, 32'd1);
        cfg_read(5'd0, d); chk("t6_addr_kept", 64'(d), 64'h300);
        cfg_read(5'd1, d); chk("t6_len_kept", 64'(d), 64'd8);
        wait_eot(n0 + 1, 400, "t6");
        repeat (10) @(negedge sys_clk_i);
        #1 chk("t6_one_frame", 64'(eot_pulses), 64'(n0 + 1));
        rdy_stall = 0;

        // Reset mid-transfer, then a normal frame.
        n0 = eot_pulses; p0 = pops_cnt;
        start_frame(32'h4000, 8, 2, 0);
        n = 0;
        while (pops_cnt - p0 < 3 && n < 100) begin
            @(negedge sys_clk_i); #1; n++;
        end
        chk("t7_three_beats", 64'(pops_cnt - p0 >= 3), 64'd1);
        do_reset(1'b1);
        repeat (10) @(negedge sys_clk_i);
        #1 chk("t7_no_eot", 64'(eot_pulses), 64'(n0));
        chk("t7_idle_valid", 64'({bus.str_valid_o, bus.tx_req_o}), 64'd0);
        n0 = eot_pulses;
        start_frame(32'h500, 2, 2, 3);
        wait_eot(n0 + 1, 100, "t7_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
